// File: rtl/rom_download_sequencer.sv
// Forwards the selected ioctl download onto the core ROM port and keeps the core in reset
// until a complete, contiguous image is resident. Optional checksum check: ROM_DOWNLOAD_SUM_EN.
module rom_download_sequencer #(
    parameter logic [7:0]  ROM_INDEX    = 8'd0,
    parameter logic [16:0] ROM_BYTES    = 17'd24576,
    parameter int          HOLD_CYCLES  = 16,
    parameter logic [15:0] EXPECTED_SUM = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic        core_reset,
    output logic        load_done,
    output logic        load_error,
    output logic [16:0] byte_count,
    output logic [15:0] sum
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        HOLD,
        DONE,
        ERROR
    } state_t;

    localparam logic [24:0] ROM_LIMIT = {8'd0, ROM_BYTES};
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic        sel;
    logic        sel_q;
    logic        sel_rise;
    logic        start_load;
    logic        accept;
    logic        in_range;
    logic        addr_gap;
    logic        count_full;
    logic        sum_ok;
    logic        load_good;
    logic        gap_err;
    logic        ovf_err;
    logic [15:0] hold_cnt;

    assign sel        = ioctl_download && (ioctl_index == ROM_INDEX);
    assign sel_rise   = sel && !sel_q;
    assign in_range   = ioctl_addr < ROM_LIMIT;
    assign addr_gap   = ioctl_addr != {8'd0, byte_count};
    assign count_full = byte_count == ROM_BYTES;
    assign load_good  = count_full && !gap_err && !ovf_err && sum_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_load = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (sel) begin
                    state_next = LOAD;
                    start_load = 1'b1;
                end
            end
            LOAD: begin
                // a strobe in the cycle sel drops still belongs to this image
                accept = ioctl_wr;
                if (!sel) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                state_next = load_good ? HOLD : ERROR;
            end
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_next = DONE;
                end
            end
            DONE, ERROR: begin
                if (sel_rise) begin
                    state_next = LOAD;
                    start_load = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q      <= 1'b0;
            dn_addr    <= '0;
            dn_data    <= '0;
            dn_wr      <= 1'b0;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            byte_count <= '0;
            gap_err    <= 1'b0;
            ovf_err    <= 1'b0;
            hold_cnt   <= '0;
        end else begin
            sel_q      <= sel;
            dn_wr      <= 1'b0;
            core_reset <= (state_next != DONE);
            load_done  <= (state_next == DONE);
            load_error <= (state_next == ERROR);
            hold_cnt   <= (state == HOLD) ? hold_cnt + 16'd1 : 16'd0;
            if (start_load) begin
                byte_count <= '0;
                gap_err    <= 1'b0;
                ovf_err    <= 1'b0;
            end else if (accept) begin
                if (in_range) begin
                    dn_wr   <= 1'b1;
                    dn_addr <= ioctl_addr[15:0];
                    dn_data <= ioctl_dout;
                    if (addr_gap) begin
                        gap_err <= 1'b1;
                    end
                    // surplus bytes saturate the count and are flagged instead of wrapping
                    if (count_full) begin
                        ovf_err <= 1'b1;
                    end else begin
                        byte_count <= byte_count + 17'd1;
                    end
                end else begin
                    ovf_err <= 1'b1;
                end
            end
        end
    end

`ifdef ROM_DOWNLOAD_SUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sum <= '0;
        end else if (start_load) begin
            sum <= '0;
        end else if (accept && in_range) begin
            sum <= sum + {8'd0, ioctl_dout};
        end
    end

    assign sum_ok = (sum == EXPECTED_SUM);
`else
    logic unused_sum_cfg;

    assign sum            = '0;
    assign sum_ok         = 1'b1;
    assign unused_sum_cfg = ^EXPECTED_SUM;
`endif

endmodule
